branch_predictor: RTL and testbench

- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) plus a branch history table (BHT) of 2-bit saturating counters.
- Returns a same-cycle taken/target prediction for the fetch PC; this is the source of the predicted target and taken values that later go into the branch resolution table.
- Consumes the BTB and BHT write ports that the branch resolution table drives at branch commit, closing the prediction/training loop.

---
 rtl/bp_pkg.sv | 40 ++++
 rtl/bp_bht.sv | 34 +++
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor:
// BTB entry layout, 2-bit BHT counter encoding and its saturating update.
package bp_pkg;

  localparam int BP_BTBSIZE = 4;
  localparam int BP_BHTSIZE = 6;

  localparam int BTB_TAG_W = 32 - BP_BTBSIZE - 2;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_cnt_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic                 is_ret;
  } btb_entry_t;

  localparam bht_cnt_t BHT_RESET = WNT;

  // Saturating step of a 2-bit direction counter toward the resolved outcome.
  function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
    bht_cnt_t nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = BHT_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_bht.sv
// Branch history table: untagged array of 2-bit saturating counters with a
// combinational read port and one training write port.
module bp_bht
  import bp_pkg::*;
#(
  parameter int BHTSIZE = BP_BHTSIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [BHTSIZE-1:0] wr_idx,
  input  logic               wr_taken,
  input  logic [BHTSIZE-1:0] rd_idx,
  output bht_cnt_t           rd_cnt
);

  localparam int BHT_ENTRIES = 1 << BHTSIZE;

  bht_cnt_t cnt_r [BHT_ENTRIES];

  // Counter array: reset to weakly-not-taken, otherwise train one entry per strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        cnt_r[i] <= BHT_RESET;
      end
    end else if (wr_en) begin
      cnt_r[wr_idx] <= bht_next(cnt_r[wr_idx], wr_taken);
    end
  end

  assign rd_cnt = cnt_r[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB plus a 2-bit counter BHT.
// Lookup is combinational from table state; training commits on the clock edge.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BTBSIZE = BP_BTBSIZE,
  parameter int BHTSIZE = BP_BHTSIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_bp_fetch_v,
  input  logic [31:0] i_bp_fetch_pc,
  output logic        o_bp_btb_hit,
  output logic        o_bp_pred_taken,
  output logic [31:0] o_bp_pred_target,
  output logic        o_bp_pred_is_ret,
  input  logic        i_bp_btb_write_en,
  input  logic [31:0] i_bp_btb_write_pc,
  input  logic [31:0] i_bp_btb_write_target,
  input  logic        i_bp_btb_write_is_ret,
  input  logic        i_bp_bht_write_en,
  input  logic [31:0] i_bp_bht_write_pc,
  input  logic        i_bp_bht_write_taken
);

  localparam int BTB_ENTRIES = 1 << BTBSIZE;
  localparam int TAG_W       = 32 - BTBSIZE - 2;

  btb_entry_t         btb_r [BTB_ENTRIES];
  btb_entry_t         fetch_entry_s;
  logic [BTBSIZE-1:0] fetch_idx_s;
  logic [BTBSIZE-1:0] wr_idx_s;
  logic [TAG_W-1:0]   fetch_tag_s;
  logic [TAG_W-1:0]   wr_tag_s;
  logic [BHTSIZE-1:0] bht_rd_idx_s;
  logic [BHTSIZE-1:0] bht_wr_idx_s;
  bht_cnt_t           bht_rd_cnt_s;
  logic               hit_s;
  logic               taken_s;
  logic [31:0]        seq_pc_s;
  logic               unused_s;

  assign fetch_idx_s  = i_bp_fetch_pc[BTBSIZE+1:2];
  assign fetch_tag_s  = i_bp_fetch_pc[31:BTBSIZE+2];
  assign wr_idx_s     = i_bp_btb_write_pc[BTBSIZE+1:2];
  assign wr_tag_s     = i_bp_btb_write_pc[31:BTBSIZE+2];
  assign bht_rd_idx_s = i_bp_fetch_pc[BHTSIZE+1:2];
  assign bht_wr_idx_s = i_bp_bht_write_pc[BHTSIZE+1:2];

  // Byte-offset bits, the BHT-side upper PC bits and the counter LSB play no role.
  assign unused_s = ^{i_bp_fetch_pc[1:0], i_bp_btb_write_pc[1:0],
                      i_bp_bht_write_pc[31:BHTSIZE+2], i_bp_bht_write_pc[1:0],
                      bht_rd_cnt_s[0]};

  // BTB: reset clears every entry; a write always overwrites the indexed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_r[i] <= '0;
      end
    end else if (i_bp_btb_write_en) begin
      btb_r[wr_idx_s] <= '{valid:  1'b1,
                           tag:    BTB_TAG_W'(wr_tag_s),
                           target: i_bp_btb_write_target,
                           is_ret: i_bp_btb_write_is_ret};
    end
  end

  bp_bht #(
    .BHTSIZE (BHTSIZE)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (i_bp_bht_write_en),
    .wr_idx   (bht_wr_idx_s),
    .wr_taken (i_bp_bht_write_taken),
    .rd_idx   (bht_rd_idx_s),
    .rd_cnt   (bht_rd_cnt_s)
  );

  // Lookup: no bypass, so a same-cycle write is seen only from the next cycle.
  always_comb begin
    fetch_entry_s    = btb_r[fetch_idx_s];
    seq_pc_s         = i_bp_fetch_pc + 32'd4;
    hit_s            = i_bp_fetch_v & fetch_entry_s.valid &
                       (fetch_entry_s.tag == BTB_TAG_W'(fetch_tag_s));
    taken_s          = hit_s & bht_rd_cnt_s[1];
    o_bp_btb_hit     = 1'b0;
    o_bp_pred_taken  = 1'b0;
    o_bp_pred_target = 32'd0;
    o_bp_pred_is_ret = 1'b0;
    if (i_bp_fetch_v) begin
      o_bp_btb_hit     = hit_s;
      o_bp_pred_taken  = taken_s;
      o_bp_pred_target = taken_s ? fetch_entry_s.target : seq_pc_s;
      o_bp_pred_is_ret = hit_s & fetch_entry_s.is_ret;
    end else begin
      o_bp_btb_hit     = 1'b0;
      o_bp_pred_taken  = 1'b0;
      o_bp_pred_target = 32'd0;
      o_bp_pred_is_ret = 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        fetch_v;
  logic [31:0] fetch_pc;
  logic        btb_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_is_ret;
  logic        btb_we;
  logic [31:0] btb_wpc;
  logic [31:0] btb_wtgt;
  logic        btb_wret;
  logic        bht_we;
  logic [31:0] bht_wpc;
  logic        bht_wtaken;

  int total_cnt;
  int bad_cnt;

  branch_predictor dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_bp_fetch_v          (fetch_v),
    .i_bp_fetch_pc         (fetch_pc),
    .o_bp_btb_hit          (btb_hit),
    .o_bp_pred_taken       (pred_taken),
    .o_bp_pred_target      (pred_target),
    .o_bp_pred_is_ret      (pred_is_ret),
    .i_bp_btb_write_en     (btb_we),
    .i_bp_btb_write_pc     (btb_wpc),
    .i_bp_btb_write_target (btb_wtgt),
    .i_bp_btb_write_is_ret (btb_wret),
    .i_bp_bht_write_en     (bht_we),
    .i_bp_bht_write_pc     (bht_wpc),
    .i_bp_bht_write_taken  (bht_wtaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    btb_we = 1'b0; btb_wpc = 32'd0; btb_wtgt = 32'd0; btb_wret = 1'b0;
    bht_we = 1'b0; bht_wpc = 32'd0; bht_wtaken = 1'b0;
  endtask

  task automatic btb_train(input logic [31:0] pc, input logic [31:0] tgt, input logic ret);
    btb_we = 1'b1; btb_wpc = pc; btb_wtgt = tgt; btb_wret = ret;
    tick();
    idle_writes();
  endtask

  task automatic bht_train(input logic [31:0] pc, input logic taken);
    bht_we = 1'b1; bht_wpc = pc; bht_wtaken = taken;
    tick();
    idle_writes();
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic e_hit,
                      input logic e_taken, input logic [31:0] e_tgt, input logic e_ret);
    fetch_v = 1'b1; fetch_pc = pc;
    #1;
    chk({tag, "_hit"},    {31'd0, btb_hit},     {31'd0, e_hit});
    chk({tag, "_taken"},  {31'd0, pred_taken},  {31'd0, e_taken});
    chk({tag, "_target"}, pred_target,          e_tgt);
    chk({tag, "_ret"},    {31'd0, pred_is_ret}, {31'd0, e_ret});
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst = 1'b1; fetch_v = 1'b0; fetch_pc = 32'd0;
    idle_writes();
    tick();
    tick();
    rst = 1'b0;

    look("rst", 32'h100, 1'b0, 1'b0, 32'h104, 1'b0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 1'b0);

    // Allocation starts weakly-not-taken; one taken update flips direction.
    btb_train(32'h100, 32'h200, 1'b0);
    look("alloc", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0);
    bht_train(32'h100, 1'b1);
    look("wt", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0);

    fetch_v = 1'b0; fetch_pc = 32'h100;
    #1;
    chk("nofetch_hit",    {31'd0, btb_hit},    32'd0);
    chk("nofetch_taken",  {31'd0, pred_taken}, 32'd0);
    chk("nofetch_target", pred_target,         32'd0);

    // Saturation: WT -> ST (x3 taken), then down through WT, WNT, SNT, SNT, SNT.
    for (int i = 0; i < 3; i++) bht_train(32'h100, 1'b1);
    bht_train(32'h100, 1'b0);
    look("st_wt", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
    bht_train(32'h100, 1'b0);
    look("wnt", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0);
    bht_train(32'h100, 1'b0);
    look("snt", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0);
    bht_train(32'h100, 1'b0);
    bht_train(32'h100, 1'b0);
    bht_train(32'h100, 1'b1);
    look("floor", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0);
    bht_train(32'h100, 1'b1);
    look("floor_up", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0);

    // Tag conflict at BTB index 0 evicts 0x100; 0x140 uses BHT index 16 (WNT).
    btb_train(32'h140, 32'h240, 1'b0);
    look("evict_old", 32'h100, 1'b0, 1'b0, 32'h104, 1'b0);
    look("evict_new", 32'h140, 1'b1, 1'b0, 32'h144, 1'b0);

    // Same-cycle write and lookup: pre-write contents this cycle.
    fetch_v = 1'b1; fetch_pc = 32'h304;
    btb_we = 1'b1; btb_wpc = 32'h304; btb_wtgt = 32'h404; btb_wret = 1'b0;
    #1;
    chk("hazard_same", {31'd0, btb_hit}, 32'd0);
    tick();
    idle_writes();
    look("hazard_next", 32'h304, 1'b1, 1'b0, 32'h308, 1'b0);

    // Simultaneous writes to different PCs.
    btb_we = 1'b1; btb_wpc = 32'h808; btb_wtgt = 32'h900; btb_wret = 1'b0;
    bht_we = 1'b1; bht_wpc = 32'h304; bht_wtaken = 1'b1;
    tick();
    idle_writes();
    look("dual_btb", 32'h808, 1'b1, 1'b0, 32'h80C, 1'b0);
    look("dual_bht", 32'h304, 1'b1, 1'b1, 32'h404, 1'b0);

    // Simultaneous writes to the same PC.
    btb_we = 1'b1; btb_wpc = 32'h60C; btb_wtgt = 32'h700; btb_wret = 1'b0;
    bht_we = 1'b1; bht_wpc = 32'h60C; bht_wtaken = 1'b1;
    tick();
    idle_writes();
    look("same_pc", 32'h60C, 1'b1, 1'b1, 32'h700, 1'b0);

    // Return flag; 0x500 shares BHT index 0 with 0x100 (currently WT).
    btb_train(32'h500, 32'h123, 1'b1);
    look("ret", 32'h500, 1'b1, 1'b1, 32'h123, 1'b1);

    // Reset coinciding with new writes: everything is discarded.
    rst = 1'b1;
    btb_we = 1'b1; btb_wpc = 32'h904; btb_wtgt = 32'hA00; btb_wret = 1'b1;
    bht_we = 1'b1; bht_wpc = 32'h100; bht_wtaken = 1'b1;
    tick();
    rst = 1'b0;
    idle_writes();
    look("mid_rst_500", 32'h500, 1'b0, 1'b0, 32'h504, 1'b0);
    look("mid_rst_drop", 32'h904, 1'b0, 1'b0, 32'h908, 1'b0);
    look("mid_rst_808", 32'h808, 1'b0, 1'b0, 32'h80C, 1'b0);
    btb_train(32'h100, 32'h200, 1'b0);
    look("mid_rst_bht", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
